mvm_pingpong_gen: RTL and testbench
===================================

MVM_PINGPONG_GEN -- requirements
Module: mvm_pingpong_gen

Interface
REQ-001 SHALL have parameter M, default 4, matrix rows and output results per job (2..16).
REQ-002 SHALL have parameter N, default 4, matrix columns and vector length (2..16).
REQ-003 SHALL have parameter IW, default 8, signed input element width.
REQ-004 SHALL have parameter OW, default 16, signed output result width (OW >= IW+1).
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port data_in, input, IW, signed input stream element.
REQ-008 SHALL have port s_valid, input, 1, data_in valid.
REQ-009 SHALL have port s_ready, output, 1, block accepts data_in.
REQ-010 SHALL have port data_out, output, OW, signed result.
REQ-011 SHALL have port m_valid, output, 1, data_out valid.
REQ-012 SHALL have port m_ready, input, 1, downstream accepts data_out.
REQ-013 SHALL have port overflow, output, 1, current data_out exceeded signed OW range; qualified by m_valid.

Function
REQ-014 SHALL transfer an input beat only in a cycle with s_valid & s_ready, and an output beat only with m_valid & m_ready.
REQ-015 SHALL treat one job as M*N matrix elements in row-major order followed by N vector elements, then emit M results y[i] = sum_j W[i][j]*x[j], row 0 first.
REQ-016 SHALL hold two job banks (ping/pong); loading fills the free bank while the other computes/outputs.
REQ-017 SHALL run a load FSM LOAD_W -> LOAD_X -> (LOAD_W on other bank if free, else FULL); FULL -> LOAD_W the cycle after a bank is released.
REQ-018 SHALL drive s_ready low in FULL and high in LOAD_W/LOAD_X.
REQ-019 SHALL run a compute FSM IDLE -> MAC (N cycles, one column per cycle, all M rows in parallel) -> DRAIN (2 cycles) -> OUT (until M results handshaken) -> next loaded bank's MAC or IDLE.
REQ-020 SHALL enter MAC the cycle after the final vector-element handshake when compute is IDLE; first m_valid exactly N+3 cycles after that handshake.
REQ-021 SHALL process banks strictly in load order; compute never reads a bank being loaded.
REQ-022 SHALL accumulate at full precision, 2*IW+clog2(N) bits signed, with no intermediate wrap.
REQ-023 SHALL set overflow=1 for a result whose full-precision value is outside [-2^(OW-1), 2^(OW-1)-1].
REQ-024 SHALL hold data_out/overflow stable while m_valid & !m_ready.
REQ-025 SHALL release a bank the cycle after its M-th output handshake; a simultaneous load-complete and release SHALL leave the load FSM in LOAD_W with no lost beat.
REQ-026 SHALL tolerate arbitrary s_valid gaps and m_ready stalls without data loss or duplication.

Reset
REQ-027 SHALL on reset force s_ready=0 for the reset cycle, then 1; m_valid=0, data_out=0, overflow=0.
REQ-028 SHALL on reset empty both banks, discard partial loads and in-flight results, and return FSMs to LOAD_W (bank ping) and IDLE.

Configuration
REQ-029 SHALL support macro MVM_SATURATE_EN: defined -> out-of-range results clamp to 2^(OW-1)-1 / -2^(OW-1); undefined -> data_out is the low OW bits (two's-complement wrap); overflow flag identical in both builds.

Verification (M=4, N=4, IW=8, OW=16)
REQ-030 SHALL cover: W all 1, x=1,2,3,4, m_ready=1 -> four results 10, overflow=0, first m_valid 7 cycles after last x beat.
REQ-031 SHALL cover: W all 127, x all 127 -> 64516 full precision; overflow=1; data_out -1020 (wrap) or 32767 (MVM_SATURATE_EN).
REQ-032 SHALL cover: W row0 all -128, x all 127 -> row0 -65024, overflow=1, data_out 512 (wrap) or -32768 (saturate).
REQ-033 SHALL cover: three jobs back-to-back, m_ready=0 -> s_ready falls after job 2 completes; raising m_ready yields all 12 results in order.
REQ-034 SHALL cover: reset asserted after 9 of 20 beats of a job -> no m_valid; a fresh complete job afterwards yields correct results.
REQ-035 SHALL cover: s_valid toggling every cycle and m_ready random 50% -> results match the reference model.

Source files
------------

// File: rtl/mvm_pingpong_gen.sv
// -----------------------------------------------------------------------------
// mvm_pingpong_gen
//   Streaming matrix-vector multiplier with two job banks (ping/pong).
//   One job is M*N matrix elements in row-major order followed by N vector
//   elements on the input stream. The block emits M signed results
//   y[i] = sum_j W[i][j]*x[j], row 0 first. While one bank is being
//   computed/output, the other bank can be loaded.
//
//   Optional build macro:
//     MVM_SATURATE_EN  defined   -> out-of-range results clamp to the OW range
//                      undefined -> data_out carries the low OW bits (wrap)
//     The overflow flag behaves identically in both builds.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset     : synchronous active-high reset
//   data_in   : signed input stream element (IW bits)
//   s_valid   : data_in valid
//   s_ready   : block accepts data_in (registered)
//   data_out  : signed result (OW bits, registered)
//   m_valid   : data_out valid (registered)
//   m_ready   : downstream accepts data_out
//   overflow  : full-precision result of the current data_out lies outside the
//               signed OW range; qualified by m_valid
// -----------------------------------------------------------------------------
module mvm_pingpong_gen #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int IW = 8,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [IW-1:0] data_in,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic signed [OW-1:0] data_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overflow
);

    localparam int PW = 2 * IW;                   // product width
    localparam int AW = 2 * IW + $clog2(N);       // full-precision accumulator
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);
    localparam int XW = ((AW > OW) ? AW : OW) + 1; // range-check width

    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_INC  = RW'(1);
    localparam logic [CW-1:0] COL_INC  = CW'(1);

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_X = 2'd1,
        FULL   = 2'd2
    } load_state_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAC     = 3'd1,
        DRAIN_A = 3'd2,
        DRAIN_B = 3'd3,
        OUT     = 3'd4
    } comp_state_t;

    load_state_t load_state_r, load_next_s;
    comp_state_t comp_state_r, comp_next_s;

    logic                 load_bank_r;
    logic                 comp_bank_r;
    logic [1:0]           full_r;
    logic [RW-1:0]        ld_row_r;
    logic [CW-1:0]        ld_col_r;
    logic [CW-1:0]        mac_col_r;
    logic [RW-1:0]        out_idx_r;
    logic                 prod_vld_r;
    logic                 s_ready_r;
    logic                 m_valid_r;
    logic                 overflow_r;
    logic signed [OW-1:0] data_out_r;

    logic signed [IW-1:0] w_mem_r [2][M][N];
    logic signed [IW-1:0] x_mem_r [2][N];
    logic signed [PW-1:0] prod_r  [M];
    logic signed [AW-1:0] acc_r   [M];

    logic s_hs_s;
    logic m_hs_s;
    logic w_last_s;
    logic load_done_s;
    logic release_s;
    logic start_s;
    logic next_ready_s;

    // Range check plus output shaping of one full-precision result: {ovf, value}.
    function automatic logic [OW:0] shape_result(input logic signed [AW-1:0] acc);
        logic signed [XW-1:0] ext;
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        logic                 ovf;
        logic [OW-1:0]        val;
        ext = XW'(acc);
        hi  = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        lo  = ~hi;
        ovf = (ext > hi) || (ext < lo);
`ifdef MVM_SATURATE_EN
        if (ext > hi) begin
            val = hi[OW-1:0];
        end else if (ext < lo) begin
            val = lo[OW-1:0];
        end else begin
            val = ext[OW-1:0];
        end
`else
        val = ext[OW-1:0];
`endif
        return {ovf, val};
    endfunction

    assign s_hs_s      = s_valid && s_ready_r;
    assign m_hs_s      = m_valid_r && m_ready;
    assign w_last_s    = (ld_row_r == ROW_LAST) && (ld_col_r == COL_LAST);
    assign load_done_s = s_hs_s && (load_state_r == LOAD_X) && (ld_col_r == COL_LAST);
    assign release_s   = m_hs_s && (comp_state_r == OUT) && (out_idx_r == ROW_LAST);
    // A bank becomes computable either when already full or when its last beat lands now.
    assign start_s      = full_r[comp_bank_r] || (load_done_s && (load_bank_r == comp_bank_r));
    assign next_ready_s = full_r[~comp_bank_r] || (load_done_s && (load_bank_r != comp_bank_r));

    assign s_ready  = s_ready_r;
    assign m_valid  = m_valid_r;
    assign data_out = data_out_r;
    assign overflow = overflow_r;

    // Load FSM next-state logic.
    always_comb begin
        load_next_s = load_state_r;
        case (load_state_r)
            LOAD_W: begin
                if (s_hs_s && w_last_s) begin
                    load_next_s = LOAD_X;
                end else begin
                    load_next_s = LOAD_W;
                end
            end
            LOAD_X: begin
                if (load_done_s) begin
                    // The other bank is usable if empty or being released this very cycle.
                    if (!full_r[~load_bank_r] || (release_s && (comp_bank_r != load_bank_r))) begin
                        load_next_s = LOAD_W;
                    end else begin
                        load_next_s = FULL;
                    end
                end else begin
                    load_next_s = LOAD_X;
                end
            end
            FULL: begin
                if (!full_r[load_bank_r]) begin
                    load_next_s = LOAD_W;
                end else begin
                    load_next_s = FULL;
                end
            end
            default: load_next_s = LOAD_W;
        endcase
    end

    // Compute FSM next-state logic.
    always_comb begin
        comp_next_s = comp_state_r;
        case (comp_state_r)
            IDLE: begin
                if (start_s) begin
                    comp_next_s = MAC;
                end else begin
                    comp_next_s = IDLE;
                end
            end
            MAC: begin
                if (mac_col_r == COL_LAST) begin
                    comp_next_s = DRAIN_A;
                end else begin
                    comp_next_s = MAC;
                end
            end
            DRAIN_A: comp_next_s = DRAIN_B;
            DRAIN_B: comp_next_s = OUT;
            OUT: begin
                if (release_s) begin
                    if (next_ready_s) begin
                        comp_next_s = MAC;
                    end else begin
                        comp_next_s = IDLE;
                    end
                end else begin
                    comp_next_s = OUT;
                end
            end
            default: comp_next_s = IDLE;
        endcase
    end

    // State registers and registered s_ready (low only while FULL).
    always_ff @(posedge clk) begin
        if (reset) begin
            load_state_r <= LOAD_W;
            comp_state_r <= IDLE;
            s_ready_r    <= 1'b0;
        end else begin
            load_state_r <= load_next_s;
            comp_state_r <= comp_next_s;
            s_ready_r    <= (load_next_s != FULL);
        end
    end

    // Load counters, load bank pointer and bank occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_bank_r <= 1'b0;
            ld_row_r    <= '0;
            ld_col_r    <= '0;
            full_r      <= 2'b00;
        end else begin
            if (s_hs_s) begin
                if (load_state_r == LOAD_W) begin
                    if (ld_col_r == COL_LAST) begin
                        ld_col_r <= '0;
                        ld_row_r <= w_last_s ? '0 : (ld_row_r + ROW_INC);
                    end else begin
                        ld_col_r <= ld_col_r + COL_INC;
                    end
                end else begin
                    if (ld_col_r == COL_LAST) begin
                        ld_col_r    <= '0;
                        load_bank_r <= ~load_bank_r;
                    end else begin
                        ld_col_r <= ld_col_r + COL_INC;
                    end
                end
            end
            // Loading and releasing always target different banks.
            if (load_done_s) begin
                full_r[load_bank_r] <= 1'b1;
            end
            if (release_s) begin
                full_r[comp_bank_r] <= 1'b0;
            end
        end
    end

    // Bank storage writes.
    always_ff @(posedge clk) begin
        if (s_hs_s && (load_state_r == LOAD_W)) begin
            w_mem_r[load_bank_r][ld_row_r][ld_col_r] <= data_in;
        end
        if (s_hs_s && (load_state_r == LOAD_X)) begin
            x_mem_r[load_bank_r][ld_col_r] <= data_in;
        end
    end

    // MAC pipeline: products of one column per cycle, accumulated one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_col_r  <= '0;
            prod_vld_r <= 1'b0;
            for (int i = 0; i < M; i++) begin
                prod_r[i] <= '0;
                acc_r[i]  <= '0;
            end
        end else begin
            prod_vld_r <= (comp_state_r == MAC);
            if (comp_state_r == MAC) begin
                for (int i = 0; i < M; i++) begin
                    prod_r[i] <= PW'(w_mem_r[comp_bank_r][i][mac_col_r]) *
                                 PW'(x_mem_r[comp_bank_r][mac_col_r]);
                end
                mac_col_r <= (mac_col_r == COL_LAST) ? '0 : (mac_col_r + COL_INC);
            end
            // First MAC cycle clears; no product is pending then.
            if ((comp_state_r == MAC) && (mac_col_r == '0)) begin
                for (int i = 0; i < M; i++) begin
                    acc_r[i] <= '0;
                end
            end else if (prod_vld_r) begin
                for (int i = 0; i < M; i++) begin
                    acc_r[i] <= acc_r[i] + AW'(prod_r[i]);
                end
            end
        end
    end

    // Output register, result sequencing and compute bank pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            comp_bank_r <= 1'b0;
            out_idx_r   <= '0;
            m_valid_r   <= 1'b0;
            overflow_r  <= 1'b0;
            data_out_r  <= '0;
        end else begin
            case (comp_state_r)
                DRAIN_B: begin
                    {overflow_r, data_out_r} <= shape_result(acc_r[0]);
                    m_valid_r                <= 1'b1;
                    out_idx_r                <= '0;
                end
                OUT: begin
                    if (m_hs_s) begin
                        if (out_idx_r == ROW_LAST) begin
                            m_valid_r   <= 1'b0;
                            comp_bank_r <= ~comp_bank_r;
                        end else begin
                            out_idx_r                <= out_idx_r + ROW_INC;
                            {overflow_r, data_out_r} <= shape_result(acc_r[out_idx_r + ROW_INC]);
                        end
                    end
                end
                default: begin
                    m_valid_r <= m_valid_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_pingpong_gen.sv
module tb_mvm_pingpong_gen;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int IW = 8;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [IW-1:0] data_in;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [OW-1:0] data_out;
    logic                 m_valid;
    logic                 m_ready;
    logic                 overflow;

    int vec_cnt     = 0;
    int err_cnt     = 0;
    int cyc         = 0;
    int last_hs_cyc = 0;
    bit rand_mr     = 1'b0;
    bit mr_force    = 1'b1;

    logic [OW:0] exp_q[$];
    int          job_w [M][N];
    int          job_x [N];
    bit          hold_chk = 1'b0;
    logic [OW:0] hold_v;

    mvm_pingpong_gen #(.M(M), .N(N), .IW(IW), .OW(OW)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // m_ready changes shortly after the rising edge, stable until the next one
    always @(posedge clk) begin
        #2;
        m_ready = rand_mr ? ($urandom_range(0, 1) == 1) : mr_force;
    end

    // Reference model: full-precision sum -> {overflow, data_out}
    function automatic logic [OW:0] model(input int s);
        logic [31:0]   b;
        logic          ovf;
        logic [OW-1:0] d;
        b   = s;
        ovf = (s > (2 ** (OW - 1)) - 1) || (s < -(2 ** (OW - 1)));
        d   = b[OW-1:0];
`ifdef MVM_SATURATE_EN
        if (s > (2 ** (OW - 1)) - 1) d = {1'b0, {(OW-1){1'b1}}};
        else if (s < -(2 ** (OW - 1))) d = {1'b1, {(OW-1){1'b0}}};
`endif
        return {ovf, d};
    endfunction

    // Output monitor / scoreboard: samples on the falling edge
    always @(negedge clk) begin
        logic [OW:0] e;
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                vec_cnt++;
                if (m_valid !== 1'b1 || {overflow, data_out} !== hold_v) begin
                    err_cnt++;
                    $display("FAIL stall_hold: got valid=%0b ovf=%0b data=%0d, required valid=1 ovf=%0b data=%0d",
                             m_valid, overflow, data_out, hold_v[OW], $signed(hold_v[OW-1:0]));
                end
            end
            hold_chk = (m_valid === 1'b1) && (m_ready === 1'b0);
            hold_v   = {overflow, data_out};
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_output: got ovf=%0b data=%0d, required no output",
                             overflow, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({overflow, data_out} !== e) begin
                        err_cnt++;
                        $display("FAIL result: got ovf=%0b data=%0d, required ovf=%0b data=%0d",
                                 overflow, data_out, e[OW], $signed(e[OW-1:0]));
                    end
                end
            end
        end
    end

    task automatic drive_beat(input int v, input bit gap);
        logic [31:0] t;
        int          n;
        bit          hs;
        t       = v;
        n       = 0;
        hs      = 1'b0;
        data_in = t[IW-1:0];
        s_valid = 1'b1;
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = (s_ready === 1'b1);
            if (hs) last_hs_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!hs) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL input_timeout: s_ready stayed %0b, required 1", s_ready);
        end
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_job(input bit gap);
        int s;
        for (int i = 0; i < M; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) s += job_w[i][j] * job_x[j];
            exp_q.push_back(model(s));
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) drive_beat(job_w[i][j], gap);
        for (int j = 0; j < N; j++) drive_beat(job_x[j], gap);
    endtask

    task automatic fill_random();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) job_w[i][j] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < N; j++) job_x[j] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt += 4;
        if (s_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_s_ready: got %0b, required 0", s_ready); end
        if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid: got %0b, required 0", m_valid); end
        if (data_out !== 16'sd0) begin err_cnt++; $display("FAIL reset_data_out: got %0d, required 0", data_out); end
        if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vec_cnt++;
        if (s_ready !== 1'b1) begin err_cnt++; $display("FAIL post_reset_s_ready: got %0b, required 1", s_ready); end
    endtask

    task automatic test_basic();
        int  n;
        int  lat;
        bit  seen;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) job_w[i][j] = 1;
        for (int j = 0; j < N; j++) job_x[j] = j + 1;
        send_job(1'b0);
        n    = 0;
        seen = 1'b0;
        lat  = -1;
        while (!seen && n < 50) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - last_hs_cyc;
            end
            n++;
        end
        vec_cnt++;
        if (!seen || lat != N + 3) begin
            err_cnt++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, N + 3);
        end
        wait_empty(100);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) job_w[i][j] = 127;
        for (int j = 0; j < N; j++) job_x[j] = 127;
        send_job(1'b0);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) job_w[i][j] = (i == 0) ? -128 : (i * 3 - j);
        send_job(1'b0);
        wait_empty(200);
    endtask

    task automatic test_back_to_back();
        mr_force = 1'b0;
        fill_random();
        send_job(1'b0);
        fill_random();
        send_job(1'b0);
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (s_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_s_ready: got %0b, required 0", s_ready); end
        mr_force = 1'b1;
        fill_random();
        send_job(1'b0);
        wait_empty(300);
    endtask

    task automatic test_reset_midjob();
        int bad;
        mr_force = 1'b1;
        for (int k = 0; k < 9; k++) drive_beat(k * 7 - 20, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad != 0) begin err_cnt++; $display("FAIL midjob_reset_m_valid: got %0d valid cycles, required 0", bad); end
        @(posedge clk);
        #1;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) job_w[i][j] = i + j - 3;
        job_x[0] = 2; job_x[1] = -1; job_x[2] = 5; job_x[3] = 7;
        send_job(1'b0);
        wait_empty(100);
    endtask

    task automatic test_random();
        rand_mr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fill_random();
            send_job(1'b1);
        end
        wait_empty(2000);
        rand_mr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_reset_midjob();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
